// File: rtl/hansen_uart_tx_if.sv
// hansen_uart_tx_if: store-path push port and polling status of the UART transmitter
//   wr_en, wr_data        push request from the core (master drives)
//   fifo_full/empty/count FIFO occupancy status (slave drives)
//   busy, overflow        serializer activity and sticky drop flag (slave drives)
interface hansen_uart_tx_if #(parameter int FIFO_DEPTH = 16);
    logic                          wr_en;
    logic [7:0]                    wr_data;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          busy;
    logic                          overflow;
    modport master (output wr_en, wr_data, input fifo_full, fifo_empty, fifo_count, busy, overflow);
    modport slave  (input wr_en, wr_data, output fifo_full, fifo_empty, fifo_count, busy, overflow);
endinterface

// File: rtl/hansen_uart_tx.sv
// hansen_uart_tx: FIFO-buffered 8N1 UART transmitter, LSB first
//   clk      system clock, rising edge
//   reset_n  synchronous active-low reset
//   bus      push port (wr_en/wr_data) and status (fifo_full/empty/count, busy, overflow)
//   tx       serial line, idle high
module hansen_uart_tx #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    hansen_uart_tx_if.slave        bus,
    output logic                   tx
);
    localparam int CPB = CLK_HZ / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(CPB);

    if (CPB < 2) begin : g_bad_cpb
        $error("CLKS_PER_BIT must be >= 2");
    end
    if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count, count_n;
    logic          full, empty, busy, overflow;
    logic          push, pop, tick;

    assign bus.fifo_full  = full;
    assign bus.fifo_empty = empty;
    assign bus.fifo_count = count;
    assign bus.busy       = busy;
    assign bus.overflow   = overflow;

    always_comb begin
        push    = bus.wr_en && !full;
        tick    = cnt == CW'(CPB - 1);
        state_n = state;
        cnt_n   = tick ? '0 : cnt + 1'b1;
        idx_n   = idx;
        shift_n = shift;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rptr];
                    state_n = START;
                end
            end
            START: if (tick) begin
                state_n = DATA;
                idx_n   = '0;
            end
            DATA: if (tick) begin
                shift_n = shift >> 1;
                idx_n   = idx + 3'd1;
                if (idx == 3'd7) state_n = STOP;
            end
            STOP: if (tick) begin
                // back-to-back frames: reload straight from the FIFO without passing IDLE
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rptr];
                    state_n = START;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        count_n = count + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            shift    <= '0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            busy     <= 1'b0;
            overflow <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            shift    <= shift_n;
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count    <= count_n;
            full     <= count_n == (AW+1)'(FIFO_DEPTH);
            empty    <= count_n == '0;
            busy     <= state_n != IDLE || count_n != '0;
            overflow <= overflow | (bus.wr_en & full);
            // line level follows the current state, so it lags the state register by one cycle
            tx       <= state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= bus.wr_data;
    end

    a_wr_data_known: assert property (@(posedge clk) disable iff (!reset_n) bus.wr_en |-> !$isunknown(bus.wr_data));
endmodule
